// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps a single read outstanding to
// instruction memory and holds the returned word for decode via valid/ready.
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] target;

    assign target = pc_next & ~32'h0000_0003;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // A redirect retargets the PC in every state; only a live response
    // without a redirect advances it instead.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (pc_load) begin
            pc_d = target;
        end
        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    if (pc_load) begin
                        discard_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q || pc_load) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end else if (pc_load) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (pc_load || instr_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: directed scenarios plus randomized
// traffic checked against a transaction-level fetch model.
module tb_cpu_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_next = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // second instance checks the PC wrap out of a top-of-memory reset PC
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .pc_load(pc_load), .pc_next(pc_next),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    cpu_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(32'h0000_0013), .pc_load(1'b0), .pc_next(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc)
    );

    // always-ready memory with fixed 1-cycle latency for the wrap instance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_rsp_valid <= 1'b0;
        else        w_rsp_valid <= w_req_valid;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) + 32'h0000_0113;
    endfunction

    // transaction-level model: next fetch PC, one outstanding read, held word
    logic [31:0] m_pc, m_out_addr, m_instr, m_ipc;
    bit          m_boot, m_out, m_kill, m_hold;
    int          m_cnt;

    task automatic model_reset();
        m_pc = 32'h0; m_out_addr = '0; m_instr = NOP; m_ipc = 32'h0;
        m_boot = 1'b1; m_out = 1'b0; m_kill = 1'b0; m_hold = 1'b0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; pc_load = 1'b0;
        instr_ready = 1'b0; pc_next = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // one clock: drive inputs (memory answers from the model), advance the model
    task automatic step(input bit rdy, input int lat, input bit ld,
                        input logic [31:0] nxt, input bit irdy);
        bit          acc, rsp;
        logic [31:0] old_pc;
        rsp = m_out && (m_cnt == 0);
        acc = !m_boot && !m_out && !m_hold && rdy;
        imem_req_ready = rdy; pc_load = ld; pc_next = nxt; instr_ready = irdy;
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? mem(m_out_addr) : $urandom;
        @(posedge clk);
        old_pc = m_pc;
        m_boot = 1'b0;
        if (m_hold && (irdy || ld)) m_hold = 1'b0;
        if (m_out) begin
            if (rsp) begin
                m_out = 1'b0;
                if (!m_kill && !ld) begin
                    m_hold = 1'b1; m_instr = mem(m_out_addr);
                    m_ipc = m_out_addr; m_pc = m_out_addr + 32'd4;
                end
                m_kill = 1'b0;
            end else begin
                m_cnt--;
                if (ld) m_kill = 1'b1;
            end
        end
        if (acc) begin
            m_out = 1'b1; m_out_addr = old_pc; m_cnt = lat - 1; m_kill = ld;
        end
        if (ld) m_pc = {nxt[31:2], 2'b00};
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got=%h exp=0", imem_req_addr); end
    endtask

    task automatic test_first_fetch();
        step(1, 1, 0, 0, 0);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        step(1, 1, 0, 0, 0);
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL first_wait got=%0b/%0b exp=0/0", imem_req_valid, instr_valid); end
        step(1, 1, 0, 0, 0);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin errors++; $display("FAIL first_instr got=%0b/%h/%h exp=1/00500093/0", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL hold_stall cyc=%0d got=%0b/%h/%h/req%0b exp=1/00500093/0/req0", i, instr_valid, instr, instr_pc, imem_req_valid);
            end
        end
        step(1, 1, 0, 0, 1);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("FAIL hold_release got=%0b/%h exp=1/4", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 1, 0, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            step(1, 1, 0, 0, 1);
            checks++; if (instr_valid !== (k % 3 == 2)) begin errors++; $display("FAIL b2b_valid k=%0d got=%0b exp=%0b", k, instr_valid, (k % 3 == 2)); end
            if (k % 3 == 2) begin
                checks++; if (instr_pc !== 32'(4 * (k / 3)) || instr !== mem(32'(4 * (k / 3)))) begin
                    errors++; $display("FAIL b2b_instr k=%0d got=%h/%h exp=%h", k, instr_pc, instr, 32'(4 * (k / 3)));
                end
            end
            if (k % 3 == 0) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * (k / 3))) begin
                    errors++; $display("FAIL b2b_req k=%0d got=%0b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, 32'(4 * (k / 3)));
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step(1, 3, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        step(1, 3, 1, 32'h0000_0103, 1);
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_wait got=%0b/%0b exp=0/0", instr_valid, imem_req_valid); end
        step(1, 3, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++; $display("FAIL rw_drop got=%0b/%0b/%h exp=0/1/100", instr_valid, imem_req_valid, imem_req_addr);
        end
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem(32'h100)) begin
            errors++; $display("FAIL rw_fetch got=%0b/%h/%h exp=1/100/%h", instr_valid, instr_pc, instr, mem(32'h100));
        end
    endtask

    task automatic test_redirect_rsp_hold();
        do_reset();
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 1, 32'h0000_0200, 1);
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL rr_rsp got=%0b/%0b/%h exp=0/1/200", instr_valid, imem_req_valid, imem_req_addr);
        end
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL rr_fetch got=%0b/%h exp=1/200", instr_valid, instr_pc); end
        step(1, 1, 1, 32'h0000_0302, 1);
        checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            errors++; $display("FAIL rr_hold got=%0b/%0b/%h exp=0/1/300", instr_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        int          nreq;
        logic [31:0] a0, a1;
        do_reset();
        checks++; if (w_instr_pc !== 32'hFFFF_FFFC || w_req_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_reset got=%h/%h exp=fffffffc", w_instr_pc, w_req_addr);
        end
        step(0, 1, 1, 32'hFFFF_FFFF, 0);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir got=%0b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr got=%0b/%h exp=1/fffffffc", instr_valid, instr_pc); end
        step(1, 1, 0, 0, 1);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        do_reset();
        nreq = 0; a0 = '0; a1 = '1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w_req_valid) begin
                if (nreq == 0) a0 = w_req_addr;
                else if (nreq == 1) a1 = w_req_addr;
                nreq++;
            end
        end
        checks++; if (nreq < 2 || a0 !== 32'hFFFF_FFFC || a1 !== 32'h0) begin
            errors++; $display("FAIL wrap_param got=n%0d/%h/%h exp=n>=2/fffffffc/0", nreq, a0, a1);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 3, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        checks++; if (imem_req_addr !== 32'h4 || instr !== mem(32'h0) || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rst_pre got=%h/%h/%0b exp=4/%h/0", imem_req_addr, instr, imem_req_valid, mem(32'h0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 32'h0 || instr !== NOP || instr_pc !== 32'h0 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async got=%h/%h/%h/%0b/%0b exp=0/%h/0/0/0", imem_req_addr, instr, instr_pc, instr_valid, imem_req_valid, NOP);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom % 4 != 0, int'($urandom_range(1, 3)), $urandom % 8 == 0, $urandom, $urandom % 3 != 0);
            checks++; if (instr_valid !== m_hold) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, instr_valid, m_hold); end
            checks++; if (imem_req_valid !== (!m_boot && !m_out && !m_hold)) begin
                errors++; $display("FAIL rnd_req c=%0d got=%0b exp=%0b", c, imem_req_valid, !m_boot && !m_out && !m_hold);
            end
            if (!m_out && !m_hold) begin
                checks++; if (imem_req_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_req_addr, m_pc); end
            end
            checks++; if (instr !== m_instr || instr_pc !== m_ipc) begin
                errors++; $display("FAIL rnd_instr c=%0d got=%h/%h exp=%h/%h", c, instr, instr_pc, m_instr, m_ipc);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_rsp_hold();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
